mem_port_arbiter: RTL

Shares the single main-memory port between the instruction-cache and data-cache controllers of the RISC-V cache subsystem. It accepts read/write requests from both cache controllers and grants exactly one transaction at a time. It registers the granted address and write data, holds the grant until the memory returns `ready`, and routes `ready`/`rdata` back to the winning requester. A watchdog aborts transactions the memory never completes, so a stalled processor cannot hang forever.

---
 rtl/mem_port_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single main-memory port between the I-cache and D-cache controllers.
// Define ARB_ROUND_ROBIN_EN for round-robin contention; default build is fixed D priority.
module mem_port_arbiter #(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic [DATA_W-1:0] d_rdata,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ready,
    output logic [DATA_W-1:0] i_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              busy,
    output logic              timeout_err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_D = 2'd1,
        SERVE_I = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t              state_reg, state_next;
    logic                op_write_reg, op_write_next;
    logic [ADDR_W-1:0]   addr_reg, addr_next;
    logic [DATA_W-1:0]   wdata_reg, wdata_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic                last_grant_d_reg, last_grant_d_next;
    logic                timeout_err_reg, timeout_err_next;

    logic d_req;
    logic i_req;
    logic grant_d;
    logic serving;
    logic abort;
    logic done;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg        <= IDLE;
            op_write_reg     <= 1'b0;
            addr_reg         <= '0;
            wdata_reg        <= '0;
            cnt_reg          <= '0;
            last_grant_d_reg <= 1'b0;
            timeout_err_reg  <= 1'b0;
        end else begin
            state_reg        <= state_next;
            op_write_reg     <= op_write_next;
            addr_reg         <= addr_next;
            wdata_reg        <= wdata_next;
            cnt_reg          <= cnt_next;
            last_grant_d_reg <= last_grant_d_next;
            timeout_err_reg  <= timeout_err_next;
        end
    end

    always_comb begin
        state_next        = state_reg;
        op_write_next     = op_write_reg;
        addr_next         = addr_reg;
        wdata_next        = wdata_reg;
        cnt_next          = cnt_reg;
        last_grant_d_next = last_grant_d_reg;
        timeout_err_next  = timeout_err_reg;

        d_req = d_read | d_write;
        i_req = i_read;
`ifdef ARB_ROUND_ROBIN_EN
        // On contention the side that did not win last time gets the port.
        grant_d = d_req && (!i_req || !last_grant_d_reg);
`else
        grant_d = d_req;
`endif

        serving = (state_reg == SERVE_D) || (state_reg == SERVE_I);
        // cnt_reg holds the number of serve cycles already completed.
        abort   = serving && !mem_ready && (cnt_reg == CNT_W'(TIMEOUT - 1));

        case (state_reg)
            IDLE: begin
                if (d_req || i_req) begin
                    state_next        = grant_d ? SERVE_D : SERVE_I;
                    addr_next         = grant_d ? d_addr : i_addr;
                    op_write_next     = grant_d && d_write;
                    last_grant_d_next = grant_d;
                    cnt_next          = '0;
                    if (grant_d) begin
                        wdata_next = d_wdata;
                    end
                end
            end
            SERVE_D, SERVE_I: begin
                if (mem_ready || abort) begin
                    state_next = RELEASE;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
                if (abort) begin
                    timeout_err_next = 1'b1;
                end
            end
            RELEASE: begin
                cnt_next   = '0;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Ready is masked while reset is asserted so a dropped transaction never completes.
        done      = serving && (mem_ready || abort) && rst;
        mem_read  = serving && !op_write_reg && !abort;
        mem_write = serving && op_write_reg && !abort;
        d_ready   = done && (state_reg == SERVE_D);
        i_ready   = done && (state_reg == SERVE_I);
        d_rdata   = (d_ready && mem_ready) ? mem_rdata : '0;
        i_rdata   = (i_ready && mem_ready) ? mem_rdata : '0;
    end

    assign mem_addr    = addr_reg;
    assign mem_wdata   = wdata_reg;
    assign busy        = (state_reg != IDLE);
    assign timeout_err = timeout_err_reg;

endmodule
